// File: rtl/dcache_mem_pkg.sv
// Shared types and constants for the data-cache backing memory.
package dcache_mem_pkg;

    localparam int LINE_W      = 256;
    localparam int OFFSET_W    = 5;
    localparam int ADDR_BITS   = 32;
    localparam int INDEX_W_MAX = ADDR_BITS - OFFSET_W;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // The index field is wide enough for any ADDR_W.
    // The top slices the live bits out of it.
    typedef struct packed {
        logic                   write;
        logic [INDEX_W_MAX-1:0] index;
        logic [LINE_W-1:0]      data;
    } mem_req_t;

endpackage

// File: rtl/dcache_mem_array.sv
// Single-port line array with a registered read port.
// The storage itself is never reset.
// Only the read-data register clears, so data_o starts at zero.
module dcache_mem_array
    import dcache_mem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] r_mem [2**ADDR_W];
    logic [LINE_W-1:0] r_rdata;

    // Commit a line write
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            r_mem[idx_i] <= wdata_i;
        end
    end

    // Registered read; holds until the next read access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (en_i && !we_i) begin
            r_rdata <= r_mem[idx_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/dcache_backing_mem.sv
// Line-granular backing memory behind the data cache.
// Each request is accepted from IDLE and held for LATENCY cycles.
// It then commits or reads back, and pulses ack for one cycle.
//
// state | meaning
// IDLE  | waiting for enable_i; accepts and captures a request
// WAIT  | latency count running; inputs ignored
// ACK   | ack_o high for one cycle; next edge always returns to IDLE
module dcache_backing_mem
    import dcache_mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o,
    output logic              busy_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    mem_req_t         r_req;
    logic             w_accept;
    logic             w_done;
    logic             w_unused_bits;

    // Next-state decode; w_done marks the edge that enters ACK
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(LATENCY)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; async reset aborts any in-flight request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the request at acceptance and run the latency count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_req <= '0;
        end else if (w_accept) begin
            r_cnt       <= CNT_W'(1);
            r_req.write <= write_i;
            r_req.index <= addr_i[ADDR_BITS-1:OFFSET_W];
            r_req.data  <= data_i;
        end else if (r_state == WAIT && !w_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    dcache_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (w_done),
        .we_i    (r_req.write),
        .idx_i   (r_req.index[ADDR_W-1:0]),
        .wdata_i (r_req.data),
        .rdata_o (data_o)
    );

    assign ack_o  = (r_state == ACK);
    assign busy_o = (r_state != IDLE);

    // Byte offset and index bits above ADDR_W alias away by design.
    assign w_unused_bits = ^{addr_i[OFFSET_W-1:0], r_req.index[INDEX_W_MAX-1:ADDR_W]};

endmodule

// File: tb/tb_dcache_backing_mem.sv
// Directed bench for dcache_backing_mem.
// Instance A runs with LATENCY=10 and instance B with LATENCY=1.
// They share the request inputs but have separate enables.
module tb_dcache_backing_mem;

    logic         clk;
    logic         rst;
    logic         en_a;
    logic         en_b;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] data_a;
    logic [255:0] data_b;
    logic         ack_a;
    logic         ack_b;
    logic         busy_a;
    logic         busy_b;

    int n_vec = 0;
    int n_err = 0;

    dcache_backing_mem #(.ADDR_W(9), .LATENCY(10)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en_a), .write_i(wr), .addr_i(addr),
        .data_i(wdata), .data_o(data_a), .ack_o(ack_a), .busy_o(busy_a)
    );

    dcache_backing_mem #(.ADDR_W(9), .LATENCY(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en_b), .write_i(wr), .addr_i(addr),
        .data_i(wdata), .data_o(data_b), .ack_o(ack_b), .busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int           sel;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wd;
        logic [255:0] exp_rd;
    } vec_t;

    localparam logic [255:0] P3  = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] DB  = {8{32'hDEADBEEF}};
    localparam logic [255:0] AA  = {32{8'hAA}};
    localparam logic [255:0] H55 = {32{8'h55}};
    localparam logic [255:0] R64 = {8{32'h600DF00D}};
    localparam logic [255:0] CF  = {8{32'hCAFEF00D}};
    localparam logic [255:0] FF  = {8{32'h13579BDF}};
    localparam logic [255:0] WB  = {8{32'h0BADC0DE}};
    localparam logic [255:0] X1  = {8{32'h5A5A0001}};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, then release enable after acceptance.
    // Wait (bounded) for ack and report the latency seen.
    task automatic run_txn(input int sel, input logic w, input logic [31:0] a,
                           input logic [255:0] d, output logic [255:0] rd,
                           output int lat, output logic busy_ok, output logic ack_ok);
        @(negedge clk);
        if (sel == 0) en_a = 1'b1; else en_b = 1'b1;
        wr = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        en_a = 1'b0; en_b = 1'b0;
        lat = -1; busy_ok = 1'b1; ack_ok = 1'b1; rd = '0;
        for (int k = 0; k < 40; k++) begin
            if ((sel == 0) ? ack_a : ack_b) begin
                lat = k;
                rd  = (sel == 0) ? data_a : data_b;
                break;
            end
            if (!((sel == 0) ? busy_a : busy_b)) busy_ok = 1'b0;
            @(negedge clk);
        end
        if (!((sel == 0) ? busy_a : busy_b)) busy_ok = 1'b0;
        @(negedge clk);
        if ((sel == 0) ? ack_a : ack_b) ack_ok = 1'b0;
        if ((sel == 0) ? busy_a : busy_b) busy_ok = 1'b0;
    endtask

    initial begin
        vec_t         vecs[$];
        logic [255:0] rd;
        logic [255:0] prev;
        int           lat;
        logic         busy_ok;
        logic         ack_ok;
        int           ack1;
        int           ack2;
        int           nack;
        int unsigned  rnd;

        vecs.push_back('{sel:0, wr:1'b1, addr:32'h0000_0060, wd:P3,  exp_rd:'0});
        vecs.push_back('{sel:0, wr:1'b0, addr:32'h0000_0060, wd:'0,  exp_rd:P3});
        vecs.push_back('{sel:0, wr:1'b1, addr:32'h0000_0080, wd:DB,  exp_rd:P3});
        vecs.push_back('{sel:0, wr:1'b0, addr:32'h0000_0080, wd:'0,  exp_rd:DB});
        vecs.push_back('{sel:0, wr:1'b1, addr:32'h0000_0040, wd:AA,  exp_rd:DB});
        vecs.push_back('{sel:0, wr:1'b1, addr:32'h0000_0800, wd:R64, exp_rd:DB});
        vecs.push_back('{sel:0, wr:1'b0, addr:32'h0000_005F, wd:'0,  exp_rd:AA});
        vecs.push_back('{sel:0, wr:1'b0, addr:32'h0000_0800, wd:'0,  exp_rd:R64});
        vecs.push_back('{sel:1, wr:1'b1, addr:32'h0000_4000, wd:CF,  exp_rd:'0});
        vecs.push_back('{sel:1, wr:1'b0, addr:32'h0000_0000, wd:'0,  exp_rd:CF});
        vecs.push_back('{sel:1, wr:1'b1, addr:32'h0000_3FE0, wd:FF,  exp_rd:CF});
        vecs.push_back('{sel:1, wr:1'b0, addr:32'h0000_3FE0, wd:'0,  exp_rd:FF});
        vecs.push_back('{sel:1, wr:1'b0, addr:32'hFFFF_C01F, wd:'0,  exp_rd:CF});

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset ack_a", {255'b0, ack_a}, '0);
        check("reset busy_a", {255'b0, busy_a}, '0);
        check("reset data_a", data_a, '0);
        check("reset data_b", data_b, '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, lat, busy_ok, ack_ok);
            check($sformatf("vec%0d latency", i), 256'(lat), (vecs[i].sel == 0) ? 256'd10 : 256'd1);
            check($sformatf("vec%0d data_o", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d busy window", i), {255'b0, busy_ok}, 256'd1);
            check($sformatf("vec%0d single ack", i), {255'b0, ack_ok}, 256'd1);
        end

        // Reset in the middle of a write to line 2: nothing must commit.
        @(negedge clk);
        en_a = 1'b1; wr = 1'b1; addr = 32'h0000_0040; wdata = H55;
        @(posedge clk);
        @(negedge clk);
        en_a = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before reset", {255'b0, busy_a}, 256'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ack after async reset", {255'b0, ack_a}, '0);
        check("busy after async reset", {255'b0, busy_a}, '0);
        check("data_o after async reset", data_a, '0);
        @(negedge clk);
        rst = 1'b0;
        nack = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ack_a || busy_a) nack++;
        end
        check("no activity after abort", 256'(nack), '0);
        run_txn(0, 1'b0, 32'h0000_0040, '0, rd, lat, busy_ok, ack_ok);
        check("line 2 survives reset", rd, AA);

        // Writeback to index 32 with enable held, then refill of index 64.
        @(negedge clk);
        en_a = 1'b1; wr = 1'b1; addr = 32'h0000_0400; wdata = WB;
        @(posedge clk);
        ack1 = -1; ack2 = -1; nack = 0; rd = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ack_a) begin
                nack++;
                if (ack1 < 0) begin
                    ack1 = k;
                    wr = 1'b0; addr = 32'h0000_0800; wdata = '0;
                end else if (ack2 < 0) begin
                    ack2 = k;
                    rd = data_a;
                end
            end
            if (ack1 >= 0 && k == ack1 + 2) en_a = 1'b0;
        end
        check("writeback ack cycle", 256'(ack1), 256'd10);
        check("refill ack cycle", 256'(ack2), 256'd22);
        check("refill data", rd, R64);
        check("refill ack count", 256'(nack), 256'd2);
        run_txn(0, 1'b0, 32'h0000_0400, '0, rd, lat, busy_ok, ack_ok);
        check("writeback committed", rd, WB);

        // Input churn during WAIT; enable drops at t0+3.
        prev = data_a;
        @(negedge clk);
        en_a = 1'b1; wr = 1'b1; addr = 32'h0000_00A0; wdata = X1;
        @(posedge clk);
        ack1 = -1; nack = 0; rd = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (ack_a) begin
                nack++;
                if (ack1 < 0) begin
                    ack1 = k;
                    rd = data_a;
                end
            end
            if (k == 3) en_a = 1'b0;
            rnd = $urandom;
            wr = rnd[0];
            addr = $urandom;
            wdata = {8{$urandom}};
        end
        check("churn ack cycle", 256'(ack1), 256'd10);
        check("churn ack count", 256'(nack), 256'd1);
        check("churn data_o held", rd, prev);
        run_txn(0, 1'b0, 32'h0000_00A0, '0, rd, lat, busy_ok, ack_ok);
        check("churn write committed", rd, X1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
